// File: rtl/event_wake_responder.sv
// Named-event wake responder: per-slot IDLE/ARMED/WAKE waiters with @-race semantics.
// Define EVT_DROP_CNT_EN to add the saturating dropped-trigger counter (drop_cnt_o).
module event_wake_responder #(
    parameter int unsigned NUM_EVT    = 4,
    parameter int unsigned NUM_WAITER = 3,
    parameter int unsigned CNT_W      = 8,
    localparam int unsigned EW        = (NUM_EVT > 2) ? $clog2(NUM_EVT) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_EVT-1:0]         trig_i,
    input  logic [NUM_WAITER-1:0]      arm_valid_i,
    input  logic [NUM_WAITER*EW-1:0]   arm_evt_i,
    output logic [NUM_WAITER-1:0]      arm_ready_o,
    input  logic [NUM_WAITER-1:0]      cancel_i,
    output logic [NUM_WAITER-1:0]      wake_o,
    output logic [NUM_WAITER-1:0]      armed_o,
    output logic [NUM_WAITER-1:0]      arm_err_o
`ifdef EVT_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]           drop_cnt_o
`endif
);

    localparam int unsigned NPAD = 1 << EW;

    typedef enum logic [1:0] {StIdle, StArmed, StWake} state_t;

    state_t                state_q [NUM_WAITER];
    state_t                state_d [NUM_WAITER];
    logic   [EW-1:0]       evt_q   [NUM_WAITER];
    logic   [EW-1:0]       evt_d   [NUM_WAITER];
    logic   [NUM_WAITER-1:0] err_q, err_d;
    logic   [NPAD-1:0]     trig_pad;

    // Padding lets the latched index select a trigger bit without a range check.
    assign trig_pad = NPAD'(trig_i);

    always_comb begin
        for (int w = 0; w < NUM_WAITER; w++) begin
            state_d[w] = state_q[w];
            evt_d[w]   = evt_q[w];
            err_d[w]   = 1'b0;
            unique case (state_q[w])
                StIdle: begin
                    if (arm_valid_i[w]) begin
                        if (32'(arm_evt_i[w*EW +: EW]) < NUM_EVT) begin
                            evt_d[w]   = arm_evt_i[w*EW +: EW];
                            state_d[w] = StArmed;
                        end else begin
                            err_d[w] = 1'b1;
                        end
                    end
                end
                StArmed: begin
                    if (cancel_i[w]) begin
                        state_d[w] = StIdle;
                    end else if (trig_pad[evt_q[w]]) begin
                        state_d[w] = StWake;
                    end
                end
                StWake:  state_d[w] = StIdle;
                default: state_d[w] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WAITER; w++) begin
                state_q[w] <= StIdle;
                evt_q[w]   <= '0;
            end
            err_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WAITER; w++) begin
                state_q[w] <= state_d[w];
                evt_q[w]   <= evt_d[w];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WAITER; w++) begin
            arm_ready_o[w] = (state_q[w] == StIdle);
            armed_o[w]     = (state_q[w] == StArmed);
            wake_o[w]      = (state_q[w] == StWake);
        end
    end

    assign arm_err_o = err_q;

`ifdef EVT_DROP_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NPAD-1:0]  covered;
    logic [31:0]      drop_n;
    logic [31:0]      drop_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A trigger is consumed only by a slot that is armed and not cancelling this cycle.
    always_comb begin
        covered = '0;
        for (int w = 0; w < NUM_WAITER; w++) begin
            if (state_q[w] == StArmed && !cancel_i[w]) begin
                covered[evt_q[w]] = 1'b1;
            end
        end
        drop_n = '0;
        for (int e = 0; e < NUM_EVT; e++) begin
            if (trig_pad[e] && !covered[e]) begin
                drop_n = drop_n + 32'd1;
            end
        end
        drop_sum = 32'(cnt_q) + drop_n;
        cnt_d    = (drop_sum > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt_o = cnt_q;
`else
    // Counter disabled: no drop tracking state.
`endif

endmodule

// File: tb/tb_event_wake_responder.sv
// Directed bench for event_wake_responder: a default instance and a NUM_EVT=5/CNT_W=2
// instance for out-of-range arms and counter saturation.
module tb_event_wake_responder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [3:0] trig;
    logic [2:0] arm_valid, cancel;
    logic [5:0] arm_evt;
    logic [2:0] arm_ready, wake, armed, arm_err;

    logic [4:0] e_trig;
    logic [2:0] e_arm_valid, e_cancel;
    logic [8:0] e_arm_evt;
    logic [2:0] e_arm_ready, e_wake, e_armed, e_arm_err;

`ifdef EVT_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic [1:0] e_drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    event_wake_responder u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trig),
        .arm_valid_i (arm_valid),
        .arm_evt_i   (arm_evt),
        .arm_ready_o (arm_ready),
        .cancel_i    (cancel),
        .wake_o      (wake),
        .armed_o     (armed),
        .arm_err_o   (arm_err)
`ifdef EVT_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    event_wake_responder #(
        .NUM_EVT    (5),
        .NUM_WAITER (3),
        .CNT_W      (2)
    ) u_err (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (e_trig),
        .arm_valid_i (e_arm_valid),
        .arm_evt_i   (e_arm_evt),
        .arm_ready_o (e_arm_ready),
        .cancel_i    (e_cancel),
        .wake_o      (e_wake),
        .armed_o     (e_armed),
        .arm_err_o   (e_arm_err)
`ifdef EVT_DROP_CNT_EN
        ,
        .drop_cnt_o  (e_drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        trig = '0; arm_valid = '0; arm_evt = '0; cancel = '0;
        e_trig = '0; e_arm_valid = '0; e_arm_evt = '0; e_cancel = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check("rst_ready", 32'(arm_ready), 32'h7);
        check("rst_wake", 32'(wake), 32'h0);
        check("rst_armed", 32'(armed), 32'h0);
        check("rst_err", 32'(arm_err), 32'h0);
`ifdef EVT_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 32'h0);
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic wake on slot1 / event1
        arm_valid = 3'b010; arm_evt = 6'b00_01_00;
        tick();
        arm_valid = '0;
        check("basic_armed", 32'(armed), 32'h2);
        check("basic_ready", 32'(arm_ready), 32'h5);
        tick();
        trig = 4'b0010;
        tick();
        trig = '0;
        check("basic_wake", 32'(wake), 32'h2);
        check("basic_armed2", 32'(armed), 32'h0);
        tick();
        check("basic_wake_once", 32'(wake), 32'h0);
        check("basic_ready_back", 32'(arm_ready), 32'h7);

        // Handoff chain: expected wake order 1, 2, 1, 0, 2
        arm_valid = 3'b111; arm_evt = {2'd2, 2'd1, 2'd0};
        tick();
        arm_valid = '0;
        check("chain_armed", 32'(armed), 32'h7);
        trig = 4'b0010;
        tick();
        trig = '0;
        check("chain_w1", 32'(wake), 32'h2);
        tick();
        arm_valid = 3'b010; arm_evt = {2'd0, 2'd1, 2'd0}; trig = 4'b0100;
        tick();
        idle_inputs();
        check("chain_w2", 32'(wake), 32'h4);
        check("chain_armed2", 32'(armed), 32'h3);
        tick();
        arm_valid = 3'b100; arm_evt = {2'd2, 2'd0, 2'd0}; trig = 4'b0010;
        tick();
        idle_inputs();
        check("chain_w3", 32'(wake), 32'h2);
        check("chain_armed3", 32'(armed), 32'h5);
        tick();
        trig = 4'b0001;
        tick();
        trig = '0;
        check("chain_w4", 32'(wake), 32'h1);
        check("chain_armed4", 32'(armed), 32'h4);
        tick();
        trig = 4'b0100;
        tick();
        trig = '0;
        check("chain_w5", 32'(wake), 32'h4);
        check("chain_armed5", 32'(armed), 32'h0);
        tick();

        // Trigger in the arm cycle is not observed
        arm_valid = 3'b001; arm_evt = {2'd0, 2'd0, 2'd3}; trig = 4'b1000;
        tick();
        idle_inputs();
        check("race_nowake", 32'(wake), 32'h0);
        check("race_armed", 32'(armed), 32'h1);
        trig = 4'b1000;
        tick();
        trig = '0;
        check("race_wake", 32'(wake), 32'h1);
        tick();

        // Cancel beats a same-cycle trigger
        arm_valid = 3'b101; arm_evt = {2'd2, 2'd0, 2'd2};
        tick();
        arm_valid = '0;
        check("cancel_armed", 32'(armed), 32'h5);
        cancel = 3'b001; trig = 4'b0100;
        tick();
        idle_inputs();
        check("cancel_wake", 32'(wake), 32'h4);
        check("cancel_ready", 32'(arm_ready), 32'h3);
        tick();
        check("cancel_nowake", 32'(wake), 32'h0);
        cancel = 3'b111;
        tick();
        cancel = '0;
        check("cancel_idle_ignored", 32'(arm_ready), 32'h7);

        // Out-of-range arm on the 5-event instance (EW=3)
        e_arm_valid = 3'b010; e_arm_evt = {3'd0, 3'd5, 3'd0};
        tick();
        idle_inputs();
        check("err_pulse", 32'(e_arm_err), 32'h2);
        check("err_ready", 32'(e_arm_ready), 32'h7);
        check("err_armed", 32'(e_armed), 32'h0);
        tick();
        check("err_once", 32'(e_arm_err), 32'h0);
        e_arm_valid = 3'b100; e_arm_evt = {3'd4, 3'd0, 3'd0};
        tick();
        idle_inputs();
        check("e4_armed", 32'(e_armed), 32'h4);
        check("e4_noerr", 32'(e_arm_err), 32'h0);
        e_trig = 5'b10000;
        tick();
        e_trig = '0;
        check("e4_wake", 32'(e_wake), 32'h4);
        tick();

`ifdef EVT_DROP_CNT_EN
        check("e_drop_zero", 32'(e_drop_cnt), 32'h0);
        e_trig = 5'b00001;
        tick();
        check("e_drop_one", 32'(e_drop_cnt), 32'h1);
        e_trig = 5'b00111;
        tick();
        check("e_drop_sat", 32'(e_drop_cnt), 32'h3);
        e_trig = 5'b00011;
        tick();
        e_trig = '0;
        check("e_drop_hold", 32'(e_drop_cnt), 32'h3);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("drop_cleared", 32'(drop_cnt), 32'h0);
        tick();
        trig = 4'b1111;
        tick();
        trig = '0;
        check("drop_four", 32'(drop_cnt), 32'h4);
        arm_valid = 3'b001; arm_evt = {2'd0, 2'd0, 2'd0};
        tick();
        arm_valid = '0;
        trig = 4'b0011;
        tick();
        trig = '0;
        check("drop_covered", 32'(drop_cnt), 32'h5);
        check("drop_cov_wake", 32'(wake), 32'h1);
        tick();
        arm_valid = 3'b010; arm_evt = {2'd0, 2'd2, 2'd0};
        tick();
        arm_valid = '0;
        cancel = 3'b010; trig = 4'b0100;
        tick();
        idle_inputs();
        check("drop_cancelled", 32'(drop_cnt), 32'h6);
        check("drop_cancel_nowake", 32'(wake), 32'h0);
`endif

        // Reset mid-wait discards the pending wait
        arm_valid = 3'b010; arm_evt = {2'd0, 2'd1, 2'd0};
        tick();
        arm_valid = '0;
        check("rstw_armed", 32'(armed), 32'h2);
        rst_n = 1'b0;
        #2;
        check("rstw_async_armed", 32'(armed), 32'h0);
        check("rstw_async_ready", 32'(arm_ready), 32'h7);
        rst_n = 1'b1;
        tick();
        trig = 4'b0010;
        tick();
        trig = '0;
        check("rstw_nowake", 32'(wake), 32'h0);
        check("rstw_notarmed", 32'(armed), 32'h0);
        tick();
        check("rstw_nowake2", 32'(wake), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
